// File: rtl/lc3_pkg.sv
// lc3_pkg
//   Shared constants and types for the LC-3 register file and PSR logic.
//   Provides:
//     - spmux_e        : SP_OUT source select encodings
//     - REG_R6, REG_R7 : stack-pointer and link register indices
//     - CC_RESET       : NZP value after reset (Z set)
//     - SSP_INIT_DEFAULT : default supervisor stack pointer on reset

package lc3_pkg;

  typedef enum logic [1:0] {
    SP_INC = 2'b00,   // SR1_OUT + 1 (pop)
    SP_DEC = 2'b01,   // SR1_OUT - 1 (push)
    SP_SSP = 2'b10,   // Saved_SSP   (enter supervisor)
    SP_USP = 2'b11    // Saved_USP   (return to user)
  } spmux_e;

  localparam logic [2:0]  REG_R6           = 3'b110;
  localparam logic [2:0]  REG_R7           = 3'b111;

  // {N,Z,P}; Z is the only legal code for a register file holding zeros.
  localparam logic [2:0]  CC_RESET         = 3'b010;

  localparam logic [15:0] SSP_INIT_DEFAULT = 16'h3000;

endpackage

// File: rtl/lc3_cc_gen.sv
// lc3_cc_gen
//   Combinational condition-code generator: classifies a bus value as
//   negative, zero or positive. Shared with the PSR write path so both
//   places agree on the classification.
// Ports:
//   bus  in  WIDTH  value to classify
//   n    out 1      sign bit set
//   z    out 1      value is zero
//   p    out 1      non-zero with sign bit clear
// Exactly one of n/z/p is high for any 2-state input.

module lc3_cc_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] bus,
  output logic             n,
  output logic             z,
  output logic             p
);

  always_comb begin
    n = bus[WIDTH-1];
    z = (bus == '0);
    // A negative value is never zero, so p is simply "neither of the others".
    p = ~n & ~z;
  end

endmodule

// File: rtl/lc3_reg_file.sv
// lc3_reg_file
//   LC-3 general-purpose register file with condition codes and the
//   supervisor/user stack-pointer shadows used on interrupt entry and RTI.
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   DR           in  3      write index
//   LD_REG       in  1      write BUS into R[DR]
//   BUS          in  WIDTH  write data for registers and condition codes
//   SR1, SR2     in  3      read indices
//   SR1_OUT      out WIDTH  R[SR1], combinational
//   SR2_OUT      out WIDTH  R[SR2], combinational
//   LD_CC        in  1      update N/Z/P from BUS
//   N, Z, P      out 1      condition codes
//   LD_SavedSSP  in  1      capture SR1_OUT into Saved_SSP
//   LD_SavedUSP  in  1      capture SR1_OUT into Saved_USP
//   SPMUX        in  2      SP_OUT source select (see lc3_pkg::spmux_e)
//   SP_OUT       out WIDTH  stack-pointer candidate for GateSP

module lc3_reg_file
  import lc3_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] SSP_INIT = WIDTH'(SSP_INIT_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic [2:0]       DR,
  input  logic             LD_REG,
  input  logic [WIDTH-1:0] BUS,

  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,

  input  logic             LD_CC,
  output logic             N,
  output logic             Z,
  output logic             P,

  input  logic             LD_SavedSSP,
  input  logic             LD_SavedUSP,
  input  logic [1:0]       SPMUX,
  output logic [WIDTH-1:0] SP_OUT
);

  localparam int NUM_REGS = 8;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] reg_we;

  logic [2:0]          nzp_q;
  logic                cc_n;
  logic                cc_z;
  logic                cc_p;

  logic [WIDTH-1:0]    saved_ssp_q;
  logic [WIDTH-1:0]    saved_usp_q;

  // Write decode. LD_REG gates every enable so an undriven DR while
  // idle cannot select a register.
  always_comb begin
    reg_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_we[i] = LD_REG && (DR == 3'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_we[i]) begin
          regs[i] <= BUS;
        end
      end
    end
  end

  // No write bypass: a write lands on the read ports after the edge.
  assign SR1_OUT = regs[SR1];
  assign SR2_OUT = regs[SR2];

  lc3_cc_gen #(
    .WIDTH (WIDTH)
  ) u_cc_gen (
    .bus (BUS),
    .n   (cc_n),
    .z   (cc_z),
    .p   (cc_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzp_q <= CC_RESET;
    end else if (LD_CC) begin
      nzp_q <= {cc_n, cc_z, cc_p};
    end
  end

  assign N = nzp_q[2];
  assign Z = nzp_q[1];
  assign P = nzp_q[0];

  // Both shadows sample the pre-edge SR1_OUT, so on interrupt entry the
  // old R6 is saved even while R6 is being reloaded in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_ssp_q <= SSP_INIT;
    end else if (LD_SavedSSP) begin
      saved_ssp_q <= SR1_OUT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saved_usp_q <= '0;
    end else if (LD_SavedUSP) begin
      saved_usp_q <= SR1_OUT;
    end
  end

  // Increment/decrement wrap modulo 2^WIDTH by truncation.
  always_comb begin
    SP_OUT = SR1_OUT + WIDTH'(1);
    case (spmux_e'(SPMUX))
      SP_INC:  SP_OUT = SR1_OUT + WIDTH'(1);
      SP_DEC:  SP_OUT = SR1_OUT - WIDTH'(1);
      SP_SSP:  SP_OUT = saved_ssp_q;
      SP_USP:  SP_OUT = saved_usp_q;
      default: SP_OUT = SR1_OUT + WIDTH'(1);
    endcase
  end

endmodule

// File: tb/tb_lc3_reg_file.sv
// Testbench for lc3_reg_file. Stimulus pushes expected output values into
// a scoreboard queue; a monitor pops and compares them on the falling edge.

module tb_lc3_reg_file;
  import lc3_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   DR = '0;
  logic         LD_REG = 1'b0;
  logic [W-1:0] BUS = '0;
  logic [2:0]   SR1 = '0;
  logic [2:0]   SR2 = '0;
  logic [W-1:0] SR1_OUT;
  logic [W-1:0] SR2_OUT;
  logic         LD_CC = 1'b0;
  logic         N, Z, P;
  logic         LD_SavedSSP = 1'b0;
  logic         LD_SavedUSP = 1'b0;
  logic [1:0]   SPMUX = 2'b00;
  logic [W-1:0] SP_OUT;

  lc3_reg_file #(
    .WIDTH    (W),
    .SSP_INIT (16'h3000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DR          (DR),
    .LD_REG      (LD_REG),
    .BUS         (BUS),
    .SR1         (SR1),
    .SR2         (SR2),
    .SR1_OUT     (SR1_OUT),
    .SR2_OUT     (SR2_OUT),
    .LD_CC       (LD_CC),
    .N           (N),
    .Z           (Z),
    .P           (P),
    .LD_SavedSSP (LD_SavedSSP),
    .LD_SavedUSP (LD_SavedUSP),
    .SPMUX       (SPMUX),
    .SP_OUT      (SP_OUT)
  );

  always #5 clk = ~clk;

  typedef enum int {K_SR1, K_SR2, K_NZP, K_SP} kind_e;
  typedef struct {
    kind_e        kind;
    logic [W-1:0] val;
    string        name;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  exp_t         mon_e;
  logic [W-1:0] mon_got;

  logic [W-1:0] vals [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                             16'h5555, 16'h6666, 16'h7777, 16'h8888};

  task automatic exp_out(input kind_e k, input logic [W-1:0] v, input string nm);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] d, input logic [W-1:0] v);
    LD_REG = 1'b1;
    DR     = d;
    BUS    = v;
    step();
    LD_REG = 1'b0;
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        case (mon_e.kind)
          K_SR1:   mon_got = SR1_OUT;
          K_SR2:   mon_got = SR2_OUT;
          K_NZP:   mon_got = {13'b0, N, Z, P};
          default: mon_got = SP_OUT;
        endcase
        n_checks++;
        if (mon_got !== mon_e.val) begin
          n_fail++;
          $display("FAIL %s: actual %h required %h", mon_e.name, mon_got, mon_e.val);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held across edges
    SPMUX = SP_SSP;
    step();
    step();
    exp_out(K_SR1, 16'h0000, "rst_sr1");
    exp_out(K_NZP, 16'h0002, "rst_nzp");
    exp_out(K_SP,  16'h3000, "rst_sp_ssp");
    step();
    rst = 1'b0;

    // After release
    SR1 = 3'd5; SR2 = 3'd7; SPMUX = SP_USP;
    exp_out(K_SR1, 16'h0000, "post_rst_sr1");
    exp_out(K_SR2, 16'h0000, "post_rst_sr2");
    exp_out(K_NZP, 16'h0002, "post_rst_nzp");
    exp_out(K_SP,  16'h0000, "post_rst_sp_usp");
    step();
    SPMUX = SP_SSP;
    exp_out(K_SP,  16'h3000, "post_rst_sp_ssp");
    step();

    // Single write, not visible until after the edge
    SR1 = 3'd3; DR = 3'd3; BUS = 16'hBEEF; LD_REG = 1'b1;
    exp_out(K_SR1, 16'h0000, "wr_same_cycle");
    step();
    LD_REG = 1'b0;
    exp_out(K_SR1, 16'hBEEF, "wr_next_cycle");
    step();

    // All eight registers, read back through both ports
    for (int i = 0; i < 8; i++) wr(3'(i), vals[i]);
    for (int i = 0; i < 8; i++) begin
      SR1 = 3'(i);
      SR2 = 3'(7 - i);
      exp_out(K_SR1, vals[i],     $sformatf("rd_sr1_r%0d", i));
      exp_out(K_SR2, vals[7 - i], $sformatf("rd_sr2_r%0d", 7 - i));
      step();
    end

    // Unknown DR with LD_REG low must not disturb anything
    DR = 'x; LD_REG = 1'b0; BUS = 16'hDEAD;
    step();
    step();
    DR = 3'd0;
    SR1 = 3'd3; SR2 = 3'd3;
    exp_out(K_SR1, 16'h4444, "xdr_sr1_same_idx");
    exp_out(K_SR2, 16'h4444, "xdr_sr2_same_idx");
    SR1 = 3'd3;
    step();

    // Condition codes
    LD_CC = 1'b1; BUS = 16'h8000;
    step();
    exp_out(K_NZP, 16'h0004, "cc_neg");
    BUS = 16'h0000;
    step();
    exp_out(K_NZP, 16'h0002, "cc_zero");
    BUS = 16'h0001;
    step();
    exp_out(K_NZP, 16'h0001, "cc_pos");
    BUS = 16'h7FFF;
    step();
    exp_out(K_NZP, 16'h0001, "cc_pos_max");
    LD_CC = 1'b0; BUS = 16'h8000;
    step();
    exp_out(K_NZP, 16'h0001, "cc_hold");
    step();

    // SP arithmetic wrap
    wr(REG_R6, 16'hFFFF);
    SR1 = REG_R6; SPMUX = SP_INC;
    exp_out(K_SP, 16'h0000, "sp_inc_wrap");
    step();
    SPMUX = SP_DEC;
    exp_out(K_SP, 16'hFFFE, "sp_dec");
    step();
    wr(REG_R6, 16'h0000);
    exp_out(K_SP, 16'hFFFF, "sp_dec_wrap");
    step();

    // Interrupt entry: old R6 saved while R6 is reloaded
    wr(REG_R6, 16'h4000);
    SR1 = REG_R6; SPMUX = SP_USP;
    LD_SavedUSP = 1'b1; LD_REG = 1'b1; DR = REG_R6; BUS = 16'h2FFF;
    exp_out(K_SP, 16'h0000, "usp_before");
    step();
    LD_SavedUSP = 1'b0; LD_REG = 1'b0;
    exp_out(K_SR1, 16'h2FFF, "int_r6_new");
    exp_out(K_SP,  16'h4000, "int_usp_saved");
    LD_SavedSSP = 1'b1;
    step();
    LD_SavedSSP = 1'b0; SPMUX = SP_SSP;
    exp_out(K_SP, 16'h2FFF, "ssp_saved");
    step();

    // Asynchronous reset mid-cycle
    SR1 = 3'd2; SR2 = 3'd7;
    exp_out(K_SR1, 16'h3333, "pre_arst_sr1");
    step();
    #1;
    rst = 1'b1;
    exp_out(K_SR1, 16'h0000, "arst_sr1");
    exp_out(K_SR2, 16'h0000, "arst_sr2");
    exp_out(K_NZP, 16'h0002, "arst_nzp");
    exp_out(K_SP,  16'h3000, "arst_sp_ssp");
    LD_REG = 1'b1; DR = 3'd2; BUS = 16'h1234;
    step();
    rst = 1'b0; LD_REG = 1'b0; SPMUX = SP_USP;
    exp_out(K_SR1, 16'h0000, "arst_wr_discard");
    exp_out(K_SP,  16'h0000, "arst_sp_usp");
    step();
    wr(3'd2, 16'h5A5A);
    exp_out(K_SR1, 16'h5A5A, "post_arst_write");
    step();

    repeat (2) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
